// File: rtl/operand_entry_circuit_flickinger.sv
// Operand entry front end of the calculator: debounces the four push buttons,
// builds a two-digit signed BCD entry from the digit switches, commits operands
// A and B, and tells the display whether to show the entry or the ALU result.

// Per-button conditioner: 2-flop synchroniser, stable-level debounce counter,
// and a single-cycle pulse on each accepted 0->1 of the stable level.
module operand_entry_circuit_flickinger_debounce #(
  parameter logic [15:0] CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic pulse
);

  logic        sync1;
  logic        sync2;
  logic        level;
  logic [15:0] cnt;

  // Synchronise, count consecutive samples that disagree with the stable level,
  // and accept the new level once CYCLES such samples have been seen in a row.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      pulse <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CYCLES - 16'd1) begin
          level <= sync2;
          cnt   <= '0;
          pulse <= sync2;
        end else begin
          cnt <= cnt + 16'd1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

module operand_entry_circuit_flickinger #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] sw_digit,
  input  logic       btn_enter,
  input  logic       btn_sign,
  input  logic       btn_load,
  input  logic       btn_clear,
  output logic [3:0] ab_msd,
  output logic [3:0] ab_lsd,
  output logic       input_sign,
  output logic       two_to_one_sel,
  output logic [8:0] op_a,
  output logic [8:0] op_b,
  output logic       calc_go,
  output logic       digit_err,
  output logic [1:0] entry_state
);

  typedef enum logic [1:0] {
    ENTRY_A = 2'd0,
    ENTRY_B = 2'd1,
    RESULT  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic p_enter, p_sign, p_load, p_clear;
  logic do_clear, do_load, do_enter, do_sign;
  logic digit_ok;

  logic [3:0] msd_d, lsd_d;
  logic       sign_d;
  logic [8:0] op_a_d, op_b_d;
  logic       err_d;
  logic       go_d;

  operand_entry_circuit_flickinger_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
    .clk(clk), .reset_n(reset_n), .raw(btn_enter), .pulse(p_enter)
  );
  operand_entry_circuit_flickinger_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_sign (
    .clk(clk), .reset_n(reset_n), .raw(btn_sign), .pulse(p_sign)
  );
  operand_entry_circuit_flickinger_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_load (
    .clk(clk), .reset_n(reset_n), .raw(btn_load), .pulse(p_load)
  );
  operand_entry_circuit_flickinger_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk(clk), .reset_n(reset_n), .raw(btn_clear), .pulse(p_clear)
  );

  // Only the highest-priority pulse of a cycle acts: clear > load > enter > sign.
  assign do_clear = p_clear;
  assign do_load  = p_load  & ~p_clear;
  assign do_enter = p_enter & ~p_load & ~p_clear;
  assign do_sign  = p_sign  & ~p_enter & ~p_load & ~p_clear;
  assign digit_ok = (sw_digit <= 4'd9);

  assign entry_state = state_q;

  // Next-state and next-value logic for the entry FSM and its data registers.
  always_comb begin
    state_d = state_q;
    msd_d   = ab_msd;
    lsd_d   = ab_lsd;
    sign_d  = input_sign;
    op_a_d  = op_a;
    op_b_d  = op_b;
    err_d   = digit_err;
    go_d    = 1'b0;
    if (do_clear) begin
      msd_d   = 4'd0;
      lsd_d   = 4'd0;
      sign_d  = 1'b0;
      op_a_d  = 9'd0;
      op_b_d  = 9'd0;
      err_d   = 1'b0;
      state_d = ENTRY_A;
    end else begin
      case (state_q)
        ENTRY_A, ENTRY_B: begin
          if (do_load) begin
            if (state_q == ENTRY_A) begin
              op_a_d  = {input_sign, ab_msd, ab_lsd};
              state_d = ENTRY_B;
            end else begin
              op_b_d  = {input_sign, ab_msd, ab_lsd};
              go_d    = 1'b1;
              state_d = RESULT;
            end
            msd_d  = 4'd0;
            lsd_d  = 4'd0;
            sign_d = 1'b0;
          end else if (do_enter) begin
            if (digit_ok) begin
              msd_d = ab_lsd;
              lsd_d = sw_digit;
              err_d = 1'b0;
            end else begin
              err_d = 1'b1;
            end
          end else if (do_sign) begin
            sign_d = ~input_sign;
          end
        end
        RESULT: begin
          // Load and sign have no effect while the result is displayed.
          if (do_enter) begin
            if (digit_ok) begin
              msd_d   = 4'd0;
              lsd_d   = sw_digit;
              sign_d  = 1'b0;
              err_d   = 1'b0;
              state_d = ENTRY_A;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        default: state_d = ENTRY_A;
      endcase
    end
  end

  // State and output registers; display select follows the next state so it
  // changes on the same edge as the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ENTRY_A;
      ab_msd         <= 4'd0;
      ab_lsd         <= 4'd0;
      input_sign     <= 1'b0;
      op_a           <= 9'd0;
      op_b           <= 9'd0;
      digit_err      <= 1'b0;
      calc_go        <= 1'b0;
      two_to_one_sel <= 1'b0;
    end else begin
      state_q        <= state_d;
      ab_msd         <= msd_d;
      ab_lsd         <= lsd_d;
      input_sign     <= sign_d;
      op_a           <= op_a_d;
      op_b           <= op_b_d;
      digit_err      <= err_d;
      calc_go        <= go_d;
      two_to_one_sel <= (state_d == RESULT);
    end
  end

endmodule
